// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer/flag controller of the async FIFO: binary/Gray write pointer,
// read-pointer synchronizer, full/almost-full/level. Optional sticky W_ovf under FIFO_WR_OVF_EN.
module fifo_wr_ptr_ctrl #(
  parameter int P_SIZE     = 4,
  parameter int DEPTH      = 8,
  parameter int NUM_STAGES = 2,
  parameter int AF_LEVEL   = 6
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  input  logic              Winc,
  input  logic [P_SIZE-1:0] R_gray_ptr,
  output logic [P_SIZE-1:0] W_addr,
  output logic [P_SIZE-1:0] W_gray_ptr,
  output logic              Wfull,
  output logic              Walmost_full,
  output logic [P_SIZE-1:0] W_level
`ifdef FIFO_WR_OVF_EN
  ,
  output logic              W_ovf
`endif
);

  localparam int AF_CLAMP = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
  localparam logic [P_SIZE-1:0] AF_LVL = P_SIZE'(AF_CLAMP);

  logic [P_SIZE-1:0] wbin_q, wbin_d;
  logic [P_SIZE-1:0] wgray_q, wgray_d;
  logic [P_SIZE-1:0] sync_q [NUM_STAGES];
  logic [P_SIZE-1:0] sync_d [NUM_STAGES];
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic [P_SIZE-1:0] wlevel_q, wlevel_d;
  logic [P_SIZE-1:0] rq_sync;
  logic [P_SIZE-1:0] rbin_s;
  logic              wr_en;

  assign rq_sync = sync_q[NUM_STAGES-1];

  always_comb begin
    sync_d[0] = R_gray_ptr;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    wr_en   = Winc & ~wfull_q;
    wbin_d  = wr_en ? wbin_q + P_SIZE'(1) : wbin_q;
    wgray_d = wbin_d ^ (wbin_d >> 1);
    rbin_s  = '0;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int unsigned i = 0; i < P_SIZE; i++) begin
      rbin_s[i] = ^(rq_sync >> i);
    end
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = (wlevel_d >= AF_LVL);
    // Full when write pointer equals read pointer with the wrap bit flipped (top two Gray bits).
    wfull_d = (wgray_d == {~rq_sync[P_SIZE-1:P_SIZE-2], rq_sync[P_SIZE-3:0]});
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= wlevel_d;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign W_addr       = {1'b0, wbin_q[P_SIZE-2:0]};
  assign W_gray_ptr   = wgray_q;
  assign Wfull        = wfull_q;
  assign Walmost_full = walmost_full_q;
  assign W_level      = wlevel_q;

`ifdef FIFO_WR_OVF_EN
  logic wovf_q, wovf_d;

  always_comb begin
    wovf_d = wovf_q | (Winc & wfull_q);
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wovf_q <= 1'b0;
    end else begin
      wovf_q <= wovf_d;
    end
  end

  assign W_ovf = wovf_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl: directed plan steps plus random traffic against an occupancy-count model.
module tb_fifo_wr_ptr_ctrl;
  localparam int P_SIZE     = 4;
  localparam int DEPTH      = 8;
  localparam int NUM_STAGES = 2;
  localparam int AF_LEVEL   = 6;
  localparam int MOD        = 2 ** P_SIZE;

  logic              W_CLK;
  logic              W_RST;
  logic              Winc;
  logic [P_SIZE-1:0] R_gray_ptr;
  logic [P_SIZE-1:0] W_addr;
  logic [P_SIZE-1:0] W_gray_ptr;
  logic              Wfull;
  logic              Walmost_full;
  logic [P_SIZE-1:0] W_level;
`ifdef FIFO_WR_OVF_EN
  logic              W_ovf;
  bit                movf;
`endif

  int total = 0;
  int bad   = 0;

  // Model: counts of words written / read, and the read count as seen after the sync delay.
  int mw;
  int mlev;
  bit mfull;
  bit maf;
  int rq[$];
  int rcnt;

  fifo_wr_ptr_ctrl #(
    .P_SIZE(P_SIZE), .DEPTH(DEPTH), .NUM_STAGES(NUM_STAGES), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .Winc(Winc), .R_gray_ptr(R_gray_ptr),
    .W_addr(W_addr), .W_gray_ptr(W_gray_ptr), .Wfull(Wfull),
    .Walmost_full(Walmost_full), .W_level(W_level)
`ifdef FIFO_WR_OVF_EN
    , .W_ovf(W_ovf)
`endif
  );

  initial W_CLK = 1'b0;
  always #5 W_CLK = ~W_CLK;

  function automatic logic [P_SIZE-1:0] to_gray(input int b);
    logic [P_SIZE-1:0] v;
    v = P_SIZE'(b % MOD);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mw = 0; mlev = 0; mfull = 0; maf = 0; rcnt = 0;
    rq.delete();
    repeat (NUM_STAGES) rq.push_back(0);
`ifdef FIFO_WR_OVF_EN
    movf = 0;
`endif
  endtask

  task automatic model_edge(input logic w, input int r);
    int rs;
    rs = rq.pop_front();
    rq.push_back(r);
`ifdef FIFO_WR_OVF_EN
    if (w && mfull) movf = 1;
`endif
    if (w && !mfull) mw = (mw + 1) % MOD;
    mlev  = (mw - rs + MOD) % MOD;
    mfull = (mlev == DEPTH);
    maf   = (mlev >= AF_LEVEL);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":addr"},  32'(W_addr),       32'(mw % DEPTH));
    chk({tag, ":gray"},  32'(W_gray_ptr),   32'(to_gray(mw)));
    chk({tag, ":full"},  32'(Wfull),        32'(mfull));
    chk({tag, ":afull"}, 32'(Walmost_full), 32'(maf));
    chk({tag, ":level"}, 32'(W_level),      32'(mlev));
`ifdef FIFO_WR_OVF_EN
    chk({tag, ":ovf"},   32'(W_ovf),        32'(movf));
`endif
  endtask

  // Drive inputs away from the edge, clock once, advance the model, check 1ns later.
  task automatic cyc(input string tag, input logic w, input int r);
    Winc = w;
    R_gray_ptr = to_gray(r);
    rcnt = r;
    @(posedge W_CLK);
    model_edge(w, r);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    W_RST = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ":addr0"}, 32'(W_addr), 32'd0);
    chk({tag, ":lvl0"},  32'(W_level), 32'd0);
    #2;
    W_RST = 1'b1;
  endtask

  initial begin
    logic [P_SIZE-1:0] gray_tab [10];
    gray_tab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hC, 4'hC};
    W_RST = 1'b1;
    Winc = 1'b0;
    R_gray_ptr = '0;
    model_reset();
    #7;

    // 1. Reset, then idle.
    async_reset("rst");
    cyc("idle0", 1'b0, 0);
    cyc("idle1", 1'b0, 0);

    // 2. Fill with reader stalled.
    for (int i = 0; i < 10; i++) begin
      cyc("fill", 1'b1, 0);
      chk("fill:gray_tab", 32'(W_gray_ptr), 32'(gray_tab[i]));
      chk("fill:lvl_tab", 32'(W_level), 32'((i < 8) ? i + 1 : 8));
    end
    chk("fill:full_const", 32'(Wfull), 32'd1);

    // 3. Overflow attempts while full.
    for (int i = 0; i < 3; i++) begin
      cyc("ovf", 1'b1, 0);
      chk("ovf:gray_hold", 32'(W_gray_ptr), 32'hC);
    end

    // 4. One read; full clears on the 3rd edge.
    cyc("drain1", 1'b0, 1);
    cyc("drain2", 1'b0, 1);
    chk("drain2:still_full", 32'(Wfull), 32'd1);
    cyc("drain3", 1'b0, 1);
    chk("drain3:full_clr", 32'(Wfull), 32'd0);
    chk("drain3:lvl7", 32'(W_level), 32'd7);

    // 5. Wrap with the reader trailing close behind.
    async_reset("rst2");
    for (int i = 0; i < 20; i++) begin
      cyc("wrap", 1'b1, (mw >= 2) ? mw - 2 : 0);
      chk("wrap:nofull", 32'(Wfull), 32'd0);
    end

    // 6. Mid-burst reset at level 5.
    async_reset("rst3");
    for (int i = 0; i < 5; i++) cyc("burst", 1'b1, 0);
    chk("burst:lvl5", 32'(W_level), 32'd5);
    #2;
    async_reset("midrst");
    chk("midrst:addr_pre", 32'(W_addr), 32'd0);
    cyc("post_rst", 1'b1, 0);
    chk("post_rst:gray1", 32'(W_gray_ptr), 32'd1);
    chk("post_rst:addr1", 32'(W_addr), 32'd1);

    // Random traffic: reader advances only over words already written.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic w;
      r = rcnt;
      if (((mw - rcnt + MOD) % MOD) > 0 && $urandom_range(0, 99) < 45) r = (rcnt + 1) % MOD;
      w = ($urandom_range(0, 99) < 60);
      cyc("rand", w, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
